// File: rtl/uart_tx.sv
// Serial UART transmitter: one word per valid/ready handshake, framed as
// start, LSB-first data, even parity, then one or two stop bits.
module uart_tx #(
    parameter int unsigned DATA_SIZE    = 8,
    parameter int unsigned STOP_BITS    = 2,
    parameter int unsigned SYS_CLK_FREQ = 50000000,
    parameter int unsigned BAUD_RATE    = 9600,
    parameter int unsigned CLKS_PER_BIT = SYS_CLK_FREQ / BAUD_RATE
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [DATA_SIZE-1:0] tx_data,
    input  logic                 tx_valid,
    output logic                 tx_ready,
    output logic                 data_tx,
    output logic                 tx_busy,
    output logic                 frame_done
);

    localparam int unsigned BAUD_W = 16;
    localparam int unsigned BIT_W  = $clog2(DATA_SIZE);
    localparam int unsigned STOP_W = 1;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_e;

    state_e               state_q, state_d;
    logic [BAUD_W-1:0]    baud_q, baud_d;
    logic [BIT_W-1:0]     bit_cnt_q, bit_cnt_d;
    logic [STOP_W-1:0]    stop_cnt_q, stop_cnt_d;
    logic [DATA_SIZE-1:0] shift_q, shift_d;
    logic                 parity_q, parity_d;
    logic                 tx_ready_q, tx_ready_d;
    logic                 data_tx_q, data_tx_d;
    logic                 tx_busy_q, tx_busy_d;
    logic                 frame_done_q, frame_done_d;

    logic                 baud_tick_c;
    logic                 handshake_c;

    assign baud_tick_c = (baud_q == BAUD_W'(CLKS_PER_BIT - 1));
    assign handshake_c = tx_valid && tx_ready_q;

    // Next-state and registered-output logic
    always_comb begin
        state_d      = state_q;
        baud_d       = baud_q;
        bit_cnt_d    = bit_cnt_q;
        stop_cnt_d   = stop_cnt_q;
        shift_d      = shift_q;
        parity_d     = parity_q;
        tx_ready_d   = tx_ready_q;
        data_tx_d    = data_tx_q;
        tx_busy_d    = tx_busy_q;
        frame_done_d = 1'b0;

        // Bit timer runs only while a frame is in flight; restarted by each handshake
        if (state_q != IDLE) begin
            baud_d = baud_tick_c ? '0 : baud_q + BAUD_W'(1);
        end

        unique case (state_q)
            IDLE: begin
                tx_ready_d = 1'b1;
                data_tx_d  = 1'b1;
                if (handshake_c) begin
                    shift_d    = tx_data;
                    parity_d   = ^tx_data;
                    tx_ready_d = 1'b0;
                    tx_busy_d  = 1'b1;
                    data_tx_d  = 1'b0;
                    baud_d     = '0;
                    state_d    = START;
                end
            end
            START: begin
                if (baud_tick_c) begin
                    data_tx_d = shift_q[0];
                    bit_cnt_d = '0;
                    state_d   = DATA;
                end
            end
            DATA: begin
                if (baud_tick_c) begin
                    if (bit_cnt_q == BIT_W'(DATA_SIZE - 1)) begin
                        data_tx_d = parity_q;
                        state_d   = PARITY;
                    end else begin
                        shift_d   = shift_q >> 1;
                        data_tx_d = shift_q[1];
                        bit_cnt_d = bit_cnt_q + BIT_W'(1);
                    end
                end
            end
            PARITY: begin
                if (baud_tick_c) begin
                    data_tx_d  = 1'b1;
                    stop_cnt_d = '0;
                    state_d    = STOP;
                end
            end
            STOP: begin
                if (baud_tick_c) begin
                    if (stop_cnt_q == STOP_W'(STOP_BITS - 1)) begin
                        state_d      = IDLE;
                        tx_busy_d    = 1'b0;
                        tx_ready_d   = 1'b1;
                        frame_done_d = 1'b1;
                    end else begin
                        stop_cnt_d = stop_cnt_q + STOP_W'(1);
                    end
                end
            end
            default: begin
                state_d   = IDLE;
                data_tx_d = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= IDLE;
            baud_q       <= '0;
            bit_cnt_q    <= '0;
            stop_cnt_q   <= '0;
            shift_q      <= '0;
            parity_q     <= 1'b0;
            tx_ready_q   <= 1'b0;
            data_tx_q    <= 1'b1;
            tx_busy_q    <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            baud_q       <= baud_d;
            bit_cnt_q    <= bit_cnt_d;
            stop_cnt_q   <= stop_cnt_d;
            shift_q      <= shift_d;
            parity_q     <= parity_d;
            tx_ready_q   <= tx_ready_d;
            data_tx_q    <= data_tx_d;
            tx_busy_q    <= tx_busy_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign tx_ready   = tx_ready_q;
    assign data_tx    = data_tx_q;
    assign tx_busy    = tx_busy_q;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx: two builds (2 and 1 stop bits) at 16 clocks per bit,
// line checked every clock against frames built from the word being sent.
module tb_uart_tx;

    localparam int unsigned CPB = 16;

    logic       clk;
    logic       rst;
    logic [7:0] tb_data;
    logic       tb_valid;
    bit         sel;

    logic tx_valid0, tx_ready0, data_tx0, tx_busy0, frame_done0;
    logic tx_valid1, tx_ready1, data_tx1, tx_busy1, frame_done1;
    logic obs_tx, obs_ready, obs_busy, obs_done;

    int checks;
    int errors;

    uart_tx #(
        .DATA_SIZE(8), .STOP_BITS(2), .SYS_CLK_FREQ(1600000), .BAUD_RATE(100000)
    ) u_dut2 (
        .clk(clk), .rst(rst), .tx_data(tb_data), .tx_valid(tx_valid0),
        .tx_ready(tx_ready0), .data_tx(data_tx0), .tx_busy(tx_busy0), .frame_done(frame_done0)
    );

    uart_tx #(
        .DATA_SIZE(8), .STOP_BITS(1), .SYS_CLK_FREQ(1600000), .BAUD_RATE(100000)
    ) u_dut1 (
        .clk(clk), .rst(rst), .tx_data(tb_data), .tx_valid(tx_valid1),
        .tx_ready(tx_ready1), .data_tx(data_tx1), .tx_busy(tx_busy1), .frame_done(frame_done1)
    );

    assign tx_valid0 = tb_valid && !sel;
    assign tx_valid1 = tb_valid && sel;
    assign obs_tx    = sel ? data_tx1    : data_tx0;
    assign obs_ready = sel ? tx_ready1   : tx_ready0;
    assign obs_busy  = sel ? tx_busy1    : tx_busy0;
    assign obs_done  = sel ? frame_done1 : frame_done0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Wait for ready, present the word, return just after the handshake edge
    task automatic send(input logic [7:0] d, input bit keep);
        int n;
        n = 0;
        @(negedge clk);
        while (!obs_ready && n < 1000) begin
            @(negedge clk);
            n++;
        end
        chk("ready_timeout", 32'(obs_ready), 32'd1);
        tb_data  = d;
        tb_valid = 1'b1;
        @(posedge clk);
        #1;
        if (!keep) tb_valid = 1'b0;
    endtask

    // Called right after the handshake edge; checks every clock of the frame
    task automatic check_frame(input logic [7:0] d, input int nstop, input string tag);
        logic exp_bit;
        for (int b = 0; b < 10 + nstop; b++) begin
            if (b == 0)      exp_bit = 1'b0;
            else if (b <= 8) exp_bit = d[b-1];
            else if (b == 9) exp_bit = ^d;
            else             exp_bit = 1'b1;
            for (int c = 0; c < int'(CPB); c++) begin
                @(negedge clk);
                chk($sformatf("%s line bit%0d clk%0d", tag, b, c), 32'(obs_tx), 32'(exp_bit));
                chk($sformatf("%s busy bit%0d", tag, b), 32'(obs_busy), 32'd1);
                chk($sformatf("%s ready bit%0d", tag, b), 32'(obs_ready), 32'd0);
                chk($sformatf("%s done bit%0d", tag, b), 32'(obs_done), 32'd0);
            end
        end
        @(negedge clk);
        chk({tag, " frame_done"}, 32'(obs_done), 32'd1);
        chk({tag, " ready_end"}, 32'(obs_ready), 32'd1);
        chk({tag, " busy_end"}, 32'(obs_busy), 32'd0);
        chk({tag, " line_end"}, 32'(obs_tx), 32'd1);
    endtask

    initial begin
        checks   = 0;
        errors   = 0;
        sel      = 1'b0;
        tb_valid = 1'b0;
        tb_data  = 8'h00;
        rst      = 1'b0;

        // Reset state on both builds
        repeat (3) @(negedge clk);
        chk("rst line", 32'(data_tx0), 32'd1);
        chk("rst ready", 32'(tx_ready0), 32'd0);
        chk("rst busy", 32'(tx_busy0), 32'd0);
        chk("rst done", 32'(frame_done0), 32'd0);
        chk("rst line1", 32'(data_tx1), 32'd1);
        chk("rst ready1", 32'(tx_ready1), 32'd0);
        rst = 1'b1;
        @(negedge clk);
        chk("ready after rst", 32'(tx_ready0), 32'd1);
        chk("ready1 after rst", 32'(tx_ready1), 32'd1);

        // Single frames: even parity 0 and 1
        send(8'hA5, 1'b0);
        check_frame(8'hA5, 2, "a5");
        @(negedge clk);
        chk("a5 done pulse", 32'(obs_done), 32'd0);
        send(8'h07, 1'b0);
        check_frame(8'h07, 2, "07");

        // One-stop-bit build: 176 clocks to frame_done
        sel = 1'b1;
        send(8'h07, 1'b0);
        check_frame(8'h07, 1, "07s1");
        sel = 1'b0;

        // Back-to-back with valid held; data change after handshake must not matter
        send(8'h3C, 1'b1);
        tb_data = 8'hC3;
        check_frame(8'h3C, 2, "b2b0");
        @(posedge clk);
        #1;
        tb_valid = 1'b0;
        check_frame(8'hC3, 2, "b2b1");
        @(negedge clk);
        chk("b2b idle line", 32'(obs_tx), 32'd1);
        chk("b2b idle busy", 32'(obs_busy), 32'd0);
        chk("b2b idle done", 32'(obs_done), 32'd0);

        // valid pulsed mid-frame is ignored
        send(8'h5A, 1'b0);
        fork
            check_frame(8'h5A, 2, "ign");
            begin
                repeat (50) @(negedge clk);
                tb_data  = 8'hFF;
                tb_valid = 1'b1;
                @(negedge clk);
                tb_valid = 1'b0;
                tb_data  = 8'h00;
            end
        join
        repeat (3) begin
            @(negedge clk);
            chk("ign no frame busy", 32'(obs_busy), 32'd0);
            chk("ign no frame line", 32'(obs_tx), 32'd1);
        end

        // Reset during data bit 3 (0x96 bit3 = 0)
        send(8'h96, 1'b0);
        repeat (72) @(negedge clk);
        chk("pre-rst line", 32'(obs_tx), 32'd0);
        chk("pre-rst busy", 32'(obs_busy), 32'd1);
        #2;
        rst = 1'b0;
        #1;
        chk("mid-rst line", 32'(obs_tx), 32'd1);
        chk("mid-rst busy", 32'(obs_busy), 32'd0);
        chk("mid-rst ready", 32'(obs_ready), 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        repeat (200) begin
            @(negedge clk);
            chk("post-rst no done", 32'(obs_done), 32'd0);
            chk("post-rst line", 32'(obs_tx), 32'd1);
        end
        send(8'h55, 1'b0);
        check_frame(8'h55, 2, "55");

        // Random words through the bench-side frame decoder
        for (int i = 0; i < 200; i++) begin
            logic [7:0] w;
            w = 8'($urandom_range(0, 255));
            send(w, 1'b0);
            check_frame(w, 2, $sformatf("rnd%0d", i));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
